// File: rtl/spi_cs_sequencer.sv
// Multi-byte SPI transaction sequencer: owns chip select, feeds bytes to a byte-level
// SPI master one at a time and returns the received bytes as one response word.
module spi_cs_sequencer #(
  parameter int unsigned MAX_BYTES     = 4,
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned CS_IDLE_CLKS  = 4,
  localparam int unsigned CW = $clog2(MAX_BYTES + 1),
  localparam int unsigned DW = 8 * MAX_BYTES
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Cmd_Valid,
  output logic          o_Cmd_Ready,
  input  logic [CW-1:0] i_Cmd_Count,
  input  logic [DW-1:0] i_Cmd_Data,
  output logic          o_Rsp_Valid,
  output logic [DW-1:0] o_Rsp_Data,
  output logic          o_Busy,
  output logic          o_SPI_CS_n,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte
);

  localparam int unsigned TMax = (CS_SETUP_CLKS > CS_HOLD_CLKS) ?
      ((CS_SETUP_CLKS > CS_IDLE_CLKS) ? CS_SETUP_CLKS : CS_IDLE_CLKS) :
      ((CS_HOLD_CLKS > CS_IDLE_CLKS) ? CS_HOLD_CLKS : CS_IDLE_CLKS);
  localparam int unsigned TW = $clog2(TMax + 2);

  localparam logic [TW-1:0] SetupLast = TW'((CS_SETUP_CLKS == 0) ? 0 : CS_SETUP_CLKS - 1);
  localparam logic [TW-1:0] HoldLast  = TW'((CS_HOLD_CLKS == 0) ? 0 : CS_HOLD_CLKS - 1);
  // GUARD includes the response cycle, so it runs CS_IDLE_CLKS + 1 cycles.
  localparam logic [TW-1:0] IdleLast  = TW'(CS_IDLE_CLKS);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSend,
    StWaitRx,
    StHold,
    StGuard
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;
  logic            cs_n_q, cs_n_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_dv_q, tx_dv_d;

  logic [CW-1:0]   eff_count;
  logic [CW-1:0]   byte_idx;
  logic [7:0]      cur_byte;

  assign eff_count = (i_Cmd_Count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : i_Cmd_Count;
  // Most significant used byte goes out first.
  assign byte_idx  = count_q - sent_q - CW'(1);

  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (byte_idx == CW'(i)) cur_byte = data_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    count_d     = count_q;
    sent_d      = sent_q;
    data_d      = data_q;
    shift_d     = shift_q;
    cs_n_d      = cs_n_q;
    tx_byte_d   = tx_byte_q;
    tx_dv_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (i_Cmd_Valid && cmd_ready_q) begin
          data_d  = i_Cmd_Data;
          count_d = eff_count;
          sent_d  = '0;
          shift_d = '0;
          timer_d = '0;
          if (eff_count == '0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            state_d     = StGuard;
          end else begin
            cs_n_d  = 1'b0;
            state_d = (CS_SETUP_CLKS == 0) ? StSend : StSetup;
          end
        end
      end
      StSetup: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == SetupLast) begin
          timer_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_TX_Ready) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = cur_byte;
          state_d   = StWaitRx;
        end
      end
      StWaitRx: begin
        if (i_RX_DV) begin
          shift_d = (shift_q << 8) | DW'(i_RX_Byte);
          sent_d  = sent_q + CW'(1);
          timer_d = '0;
          if (sent_d != count_q) begin
            state_d = StSend;
          end else if (CS_HOLD_CLKS == 0) begin
            cs_n_d      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_d;
            state_d     = StGuard;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == HoldLast) begin
          timer_d     = '0;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = shift_q;
          state_d     = StGuard;
        end
      end
      StGuard: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == IdleLast) begin
          timer_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      count_q     <= '0;
      sent_q      <= '0;
      data_q      <= '0;
      shift_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      tx_byte_q   <= '0;
      tx_dv_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      sent_q      <= sent_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      tx_byte_q   <= tx_byte_d;
      tx_dv_q     <= tx_dv_d;
    end
  end

  assign o_Cmd_Ready = cmd_ready_q;
  assign o_Rsp_Valid = rsp_valid_q;
  assign o_Rsp_Data  = rsp_data_q;
  assign o_Busy      = busy_q;
  assign o_SPI_CS_n  = cs_n_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_TX_DV     = tx_dv_q;

endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
- Transaction sequencer directly upstream of the byte-level SPI master (MSB-first, one byte per i_TX_DV pulse, 16 SCLK edges per byte).
- Accepts a multi-byte command (1..MAX_BYTES), owns the active-low chip select, and feeds bytes to the master one at a time.
- Collects the bytes the master receives and returns them to the command issuer as one response word.
- Used for analog-card ADC/DAC register accesses, which need CS held low across several bytes with setup, hold and idle guard times.

Parameters:
- MAX_BYTES, 4: maximum bytes per transaction; CW = $clog2(MAX_BYTES+1) is the count width.
- CS_SETUP_CLKS, 2: i_Clk cycles from CS_n falling to the first o_TX_DV pulse; 0 skips the setup wait.
- CS_HOLD_CLKS, 2: i_Clk cycles from the last i_RX_DV to CS_n rising; 0 skips the hold wait.
- CS_IDLE_CLKS, 4: minimum i_Clk cycles CS_n stays high before the next command is accepted; 0 skips the idle wait.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Cmd_Valid  in  1  command request
- o_Cmd_Ready  out  1  command accept window
- i_Cmd_Count  in  CW  number of bytes to transfer
- i_Cmd_Data  in  8*MAX_BYTES  TX bytes, right-aligned; first byte sent is the most significant used byte
- o_Rsp_Valid  out  1  one-cycle response pulse
- o_Rsp_Data  out  8*MAX_BYTES  RX bytes, right-aligned, unused upper bits zero
- o_Busy  out  1  high whenever the state is not IDLE
- o_SPI_CS_n  out  1  chip select, active low
- o_TX_Byte  out  8  byte to the SPI master
- o_TX_DV  out  1  one-cycle transmit strobe to the SPI master
- i_TX_Ready  in  1  SPI master ready for the next byte
- i_RX_DV  in  1  SPI master received-byte strobe
- i_RX_Byte  in  8  byte received by the SPI master

Behaviour:
- Clock and reset: i_Clk; reset i_Rst_L, asynchronous, active-low.
- Reset values:
  - o_Cmd_Ready=0, o_Rsp_Valid=0, o_Rsp_Data=0, o_Busy=0.
  - o_SPI_CS_n=1, o_TX_Byte=0, o_TX_DV=0.
  - State=IDLE; all counters 0.
  - o_Cmd_Ready goes high on the first clock after reset release.
- All outputs are registered.
- States: IDLE, SETUP, SEND, WAIT_RX, HOLD, GUARD.
- IDLE:
  - o_Cmd_Ready=1.
  - Accept occurs when i_Cmd_Valid=1 and o_Cmd_Ready=1 on the same edge.
  - On accept: latch i_Cmd_Data; effective count N = min(i_Cmd_Count, MAX_BYTES); clear the RX shift register; o_Cmd_Ready goes 0 on the next cycle.
  - N=0: CS_n is never asserted. The next cycle pulses o_Rsp_Valid with o_Rsp_Data=0, then the block enters GUARD.
  - N>0: CS_n goes 0 on the next cycle and the block enters SETUP.
- SETUP: wait CS_SETUP_CLKS cycles, then enter SEND.
- SEND:
  - While i_TX_Ready=1, pulse o_TX_DV for exactly one cycle.
  - o_TX_Byte = latched byte index (N-1-k), where k is the number of bytes already sent.
  - Then enter WAIT_RX.
  - o_TX_DV is never asserted while i_TX_Ready=0.
- WAIT_RX:
  - On i_RX_DV: shift register = (shift << 8) | i_RX_Byte; k increments.
  - If k < N, return to SEND; the next byte waits for i_TX_Ready to go high again.
  - If k = N, enter HOLD.
  - Any i_RX_DV seen outside WAIT_RX is ignored.
- HOLD:
  - Wait CS_HOLD_CLKS cycles.
  - Then, in the same cycle: CS_n=1, o_Rsp_Valid=1 for one cycle, o_Rsp_Data = shift register.
  - Enter GUARD.
- GUARD:
  - CS_n stays high for CS_IDLE_CLKS cycles, then return to IDLE.
  - CS_n high time between transactions is ≥ max(CS_IDLE_CLKS, 1) cycles.
- o_Rsp_Data holds its value until the next response; there is no response backpressure.
- i_Cmd_Valid is ignored outside IDLE; the issuer must hold the command until it is accepted.
- Response order for an N-byte read: byte received first lands in the most significant used byte; the last byte received is [7:0].
- Reset mid-transaction:
  - CS_n returns to 1 immediately, asynchronously.
  - No o_Rsp_Valid is produced; the partial response is discarded.
  - The SPI master is reset by the same i_Rst_L.

Test Plan:
- Single byte: bench pairs the block with an SPI master (mode 0, CLKS_PER_HALF_BIT=2) and MISO looped to MOSI. Command count=1, data=0x000000A5 -> one o_TX_DV with 0xA5; CS_n low ≥2 cycles before the first SCLK edge; Rsp_Data=0x000000A5; CS_n high when Rsp_Valid pulses.
- Four bytes: same loopback bench. Command count=4, data=0x12345678 -> TX order 12,34,56,78; CS_n stays low across all bytes; Rsp_Data=0x12345678; exactly one Rsp_Valid.
- Count 0 -> no TX_DV, CS_n stays 1, Rsp_Valid one cycle after accept with data 0; Cmd_Ready low for CS_IDLE_CLKS+1 cycles.
- Count 7 with MAX_BYTES=4, data=0xDEADBEEF -> clamped to 4 bytes DE,AD,BE,EF; Rsp_Data=0xDEADBEEF.
- Back-to-back: i_Cmd_Valid held high for two commands -> second accept occurs no earlier than CS_IDLE_CLKS cycles after CS_n rises; CS_n high ≥4 cycles between transactions.
- Reset mid-transfer: assert i_Rst_L=0 during byte 2 of a 3-byte command -> CS_n=1 immediately, all outputs at reset values, no Rsp_Valid; after release, a new count=1 command completes normally.
